// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types for the pipeline hazard scoreboard
package hazard_scoreboard_pkg;

  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // One in-flight register writer: valid, destination, and whether it is a load.
  typedef struct packed {
    logic       v;
    logic [2:0] wr_sel;
    logic       ld;
  } slot_t;

endpackage

// File: rtl/hazard_scoreboard_sb_slot_match.sv
// rtl/hazard_scoreboard_sb_slot_match.sv - source-operand compare against one in-flight writer
module sb_slot_match
  import hazard_scoreboard_pkg::*;
(
  input  slot_t      slot,
  input  logic [2:0] rs_sel,
  input  logic       rs_used,
  input  logic [2:0] rt_sel,
  input  logic       rt_used,
  output logic       match,
  output logic       ld_match
);

  // rs and rt naming the same register collapse into one match.
  assign match    = slot.v & ((rs_used & (slot.wr_sel == rs_sel)) |
                              (rt_used & (slot.wr_sel == rt_sel)));
  assign ld_match = match & slot.ld;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage issue/stall/bubble control with halt drain
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [2:0]       id_rs_sel,
  input  logic             id_rs_used,
  input  logic [2:0]       id_rt_sel,
  input  logic             id_rt_used,
  input  logic [2:0]       id_wr_sel,
  input  logic             id_wr_en,
  input  logic             id_mem_read,
  input  logic             id_halt,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic             halt_out,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [PIPE_DEPTH-1:0] EX_ONLY   = PIPE_DEPTH'(1);
  localparam logic [PIPE_DEPTH-1:0] EX_MEM    = PIPE_DEPTH'(3);
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};

  slot_t                 sb [PIPE_DEPTH];
  slot_t                 new_slot;
  state_e                state;
  logic [PIPE_DEPTH-1:0] match_vec;
  logic [PIPE_DEPTH-1:0] ld_match_vec;
  logic [PIPE_DEPTH-1:0] valid_vec;
  logic                  hazard;
  logic                  issue;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_slot
    sb_slot_match u_match (
      .slot     (sb[k]),
      .rs_sel   (id_rs_sel),
      .rs_used  (id_rs_used),
      .rt_sel   (id_rt_sel),
      .rt_used  (id_rt_used),
      .match    (match_vec[k]),
      .ld_match (ld_match_vec[k])
    );
    assign valid_vec[k] = sb[k].v;
  end

  // WB never contributes: the register file bypasses its own write port.
  assign hazard = (FWD_EN != 0) ? |(ld_match_vec & EX_ONLY) : |(match_vec & EX_MEM);
  assign busy   = |valid_vec;

  always_comb begin
    issue  = 1'b0;
    stall  = 1'b1;
    bubble = 1'b1;
    if (state == ST_RUN) begin
      issue  = id_valid & ~hazard & ~flush;
      stall  = id_valid & hazard & ~flush;
      bubble = ~issue;
    end
  end

  // A HALT travels down the pipe as a non-writer.
  always_comb begin
    new_slot = '0;
    if (issue & id_wr_en & ~id_halt) begin
      new_slot.v      = 1'b1;
      new_slot.wr_sel = id_wr_sel;
      new_slot.ld     = id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) sb[k] <= '0;
      state     <= ST_RUN;
      halt_out  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      sb[0] <= new_slot;
      for (int k = 1; k < PIPE_DEPTH; k++) sb[k] <= sb[k-1];
      if ((state == ST_RUN) && stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      case (state)
        ST_RUN:    if (issue & id_halt) state <= ST_DRAIN;
        ST_DRAIN:  if (!busy) begin
                     state    <= ST_HALTED;
                     halt_out <= 1'b1;
                   end
        ST_HALTED: halt_out <= 1'b1;
        default:   state <= ST_RUN;
      endcase
    end
  end

endmodule
